// File: rtl/gpu_draw_sequencer_if.sv
// Command, main-memory read and VRAM row signals of gpu_draw_sequencer.
// master: the side that issues commands and answers memory/VRAM reads.
// slave : the draw sequencer itself.
interface gpu_draw_sequencer_if #(
    parameter int MEM_AW = 12
);
    // Command handshake: a command is taken on a rising clk edge where
    // cmd_valid and cmd_ready are both high; cmd_ready is high only while idle.
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_clear;
    logic [7:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [3:0]        cmd_n;
    logic [MEM_AW-1:0] cmd_addr;

    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rd_data;

    logic [4:0]        vram_row;
    logic              vram_rd_en;
    logic [63:0]       vram_rd_data;
    logic              vram_wr_en;
    logic [63:0]       vram_wr_data;

    logic              busy;
    logic              done;
    logic [7:0]        vf;

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_n, cmd_addr,
        output mem_rd_data, vram_rd_data,
        input  cmd_ready, mem_rd_en, mem_addr, vram_row, vram_rd_en,
        input  vram_wr_en, vram_wr_data, busy, done, vf
    );

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_n, cmd_addr,
        input  mem_rd_data, vram_rd_data,
        output cmd_ready, mem_rd_en, mem_addr, vram_row, vram_rd_en,
        output vram_wr_en, vram_wr_data, busy, done, vf
    );
endinterface

// File: rtl/gpu_draw_sequencer.sv
// CHIP-8 CLS / DXYN sequencer for a 64x32 monochrome VRAM held as 32
// row words of 64 bits (bit c = column c). Each sprite row is a VRAM
// read (RD) followed by a write of the XORed word (WR).
// Optional build macro GPU_DRAW_WRAP_EN: wrap pixels past column 63 and
// rows past row 31 instead of clipping them.
module gpu_draw_sequencer #(
    parameter int MEM_AW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    gpu_draw_sequencer_if.slave  bus,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    logic              is_clear;
    logic [5:0]        x0;
    logic [4:0]        row;
    logic [3:0]        n_lat;
    logic [3:0]        i_cnt;
    logic [MEM_AW-1:0] addr;
    logic              col;
    logic              mem_rd_en_q;
    logic              vram_rd_en_q;
    logic              vram_wr_en_q;
    logic              done_q;
    logic [7:0]        vf_q;

    logic [63:0]       sprite_bits;
    logic [63:0]       mask;
    logic              hit;
    logic [5:0]        next_row;
    logic              last_row;

    // Sprite byte placed at x0 (MSB leftmost), collision bit and end-of-sprite test.
    always_comb begin
        sprite_bits = '0;
        for (int j = 0; j < 8; j++) begin
            sprite_bits[j] = bus.mem_rd_data[7-j];
        end
`ifdef GPU_DRAW_WRAP_EN
        // Rotate; a shift by 64 (x0 = 0) yields zero, so no special case.
        mask     = (sprite_bits << x0) | (sprite_bits >> (7'd64 - {1'b0, x0}));
        next_row = {1'b0, row} + 6'd1;
        last_row = ((i_cnt + 4'd1) == n_lat);
`else
        // Plain shift discards columns past 63.
        mask     = sprite_bits << x0;
        next_row = {1'b0, row} + 6'd1;
        last_row = ((i_cnt + 4'd1) == n_lat) || next_row[5];
`endif
        hit = |(bus.vram_rd_data & mask);
    end

    // Write data is the freshly read row XOR mask during WR, zero otherwise (CLR).
    assign bus.vram_wr_data = (state == S_WR) ? (bus.vram_rd_data ^ mask) : 64'd0;

    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_addr   = addr;
    assign bus.vram_row   = row;
    assign bus.vram_rd_en = vram_rd_en_q;
    assign bus.vram_wr_en = vram_wr_en_q;
    assign bus.done       = done_q;
    assign bus.vf         = vf_q;
    assign dbg_state      = state;

    // Command FSM; strobes are registered on entry to the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            is_clear     <= 1'b0;
            x0           <= '0;
            row          <= '0;
            n_lat        <= '0;
            i_cnt        <= '0;
            addr         <= '0;
            col          <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            vram_rd_en_q <= 1'b0;
            vram_wr_en_q <= 1'b0;
            done_q       <= 1'b0;
            vf_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        is_clear <= bus.cmd_clear;
                        x0       <= bus.cmd_x[5:0];
                        n_lat    <= bus.cmd_n;
                        i_cnt    <= '0;
                        col      <= 1'b0;
                        if (bus.cmd_clear) begin
                            row          <= '0;
                            vram_wr_en_q <= 1'b1;
                            state        <= S_CLR;
                        end else if (bus.cmd_n == 4'd0) begin
                            state <= S_DONE;
                        end else begin
                            row          <= bus.cmd_y[4:0];
                            addr         <= bus.cmd_addr;
                            mem_rd_en_q  <= 1'b1;
                            vram_rd_en_q <= 1'b1;
                            state        <= S_RD;
                        end
                    end
                end
                S_CLR: begin
                    if (row == 5'd31) begin
                        vram_wr_en_q <= 1'b0;
                        state        <= S_DONE;
                    end else begin
                        row <= row + 5'd1;
                    end
                end
                S_RD: begin
                    mem_rd_en_q  <= 1'b0;
                    vram_rd_en_q <= 1'b0;
                    vram_wr_en_q <= 1'b1;
                    state        <= S_WR;
                end
                S_WR: begin
                    vram_wr_en_q <= 1'b0;
                    col          <= col | hit;
                    i_cnt        <= i_cnt + 4'd1;
                    if (last_row) begin
                        state <= S_DONE;
                    end else begin
                        row          <= next_row[4:0];
                        addr         <= addr + 1'b1;
                        mem_rd_en_q  <= 1'b1;
                        vram_rd_en_q <= 1'b1;
                        state        <= S_RD;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    if (!is_clear) begin
                        vf_q <= {7'b0, col};
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
